flash_responder: RTL
====================

FLASH_RESPONDER -- requirements
Module: flash_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: clock edges waitrequest stays high after a command is first sampled in IDLE (range 1..15).
REQ-002 Parameter READ_LATENCY, default 3: clock edges from the acceptance edge to the first readdatavalid beat (range 1..15).
REQ-003 clk_clk  input  1  single clock; all logic on its rising edge.
REQ-004 reset_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 flash_mem_read  input  1  read command request.
REQ-006 flash_mem_write  input  1  write command request; accepted and discarded.
REQ-007 flash_mem_address  input  23  word address of the command.
REQ-008 flash_mem_burstcount  input  4  beats per read; 0 is treated as 1.
REQ-009 flash_mem_byteenable  input  4  per-byte enable applied to every returned beat.
REQ-010 flash_mem_writedata  input  32  ignored.
REQ-011 flash_mem_waitrequest  output  1  high = command not accepted this cycle.
REQ-012 flash_mem_readdata  output  32  returned data word.
REQ-013 flash_mem_readdatavalid  output  1  high for one cycle per returned beat.

Function
REQ-014 The block SHALL be an Avalon-MM slave emulating the flash controller read port, with pattern data in place of a memory array.
REQ-015 Data pattern for word address A SHALL be {A[15:0] ^ 16'hA5A5, A[15:0]}; each byte with byteenable bit 0 SHALL return 8'h00.
REQ-016 All outputs SHALL be registered; states: IDLE, WAIT, ACCEPT, LATENCY, BURST.
REQ-017 IDLE: waitrequest=1; read or write sampled high -> WAIT, wait counter loaded with WAIT_CYCLES-1.
REQ-018 WAIT: counter decrements per edge; at 0 -> ACCEPT with waitrequest driven 0 for exactly one cycle.
REQ-019 WAIT/ACCEPT: read and write both sampled low SHALL return to IDLE with no response (withdrawn command).
REQ-020 ACCEPT edge (waitrequest=0 and read=1): capture address, burstcount, byteenable -> LATENCY; write at that edge: discard -> IDLE, no readdatavalid.
REQ-021 read and write both high at acceptance SHALL be treated as read.
REQ-022 First readdatavalid SHALL be high in the cycle following the READ_LATENCY-th edge after acceptance; remaining beats on consecutive cycles with no gaps.
REQ-023 Beat k (0-based) SHALL use address captured+k modulo 2^23 (wrap 7FFFFF -> 000000).
REQ-024 After the last beat -> IDLE; waitrequest SHALL remain 1 from ACCEPT until return to IDLE (one outstanding command).
REQ-025 readdata SHALL hold its last value when readdatavalid=0.
REQ-026 Inputs other than read/write SHALL be ignored outside the acceptance edge.

Reset
REQ-027 reset_reset_n low SHALL immediately force state IDLE, waitrequest=1, readdatavalid=0, readdata=32'h0, counters 0, regardless of edge.
REQ-028 Reset mid-burst SHALL abort remaining beats; no readdatavalid until a new command is accepted after release.
REQ-029 First edge after release SHALL be able to sample a command in IDLE.

Verification
REQ-030 Defaults, read=1, address=23'h000123, burstcount=1, byteenable=4'b1111 held -> waitrequest low one cycle 2 edges after first sample; one beat readdata=32'hA4860123 three edges after acceptance.
REQ-031 Same with byteenable=4'b0011 -> single beat readdata=32'h00000123.
REQ-032 Burst 4 at 23'h7FFFFE, byteenable=4'b1111 -> four consecutive beats 32'h5A5BFFFE, 32'h5A5AFFFF, 32'hA5A50000, 32'hA5A40001; waitrequest stays 1 throughout.
REQ-033 write=1 at 23'h000010 -> one waitrequest-low cycle, no readdatavalid in following 20 cycles; subsequent read at 23'h000010, burstcount=0 -> exactly one beat 32'hA5B50010.
REQ-034 Read withdrawn during WAIT -> no waitrequest-low cycle, no readdatavalid; next read completes normally.
REQ-035 reset_reset_n pulsed low between beat 1 and beat 2 of a burst-4 read -> outputs reset asynchronously, no further beats; new read at 23'h0 returns 32'hA5A50000.

Source files
------------

// File: rtl/flash_responder.sv
// Avalon-MM slave that stands in for the flash controller read port.
// Reads return a deterministic address-derived pattern; writes are accepted and dropped.
module flash_responder #(
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 3
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        flash_mem_read,
    input  logic        flash_mem_write,
    input  logic [22:0] flash_mem_address,
    input  logic [3:0]  flash_mem_burstcount,
    input  logic [3:0]  flash_mem_byteenable,
    input  logic [31:0] flash_mem_writedata,
    output logic        flash_mem_waitrequest,
    output logic [31:0] flash_mem_readdata,
    output logic        flash_mem_readdatavalid
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WAIT    = 3'd1;
    localparam logic [2:0] ACCEPT  = 3'd2;
    localparam logic [2:0] LATENCY = 3'd3;
    localparam logic [2:0] BURST   = 3'd4;

    logic [2:0]  state;
    logic [3:0]  wait_cnt;
    logic [3:0]  lat_cnt;
    logic [3:0]  beats_left;
    logic [22:0] cur_addr;
    logic [3:0]  cur_be;

    // Write data never reaches storage; fold it away so it is visibly consumed.
    logic unused_writedata;
    assign unused_writedata = ^flash_mem_writedata;

    function automatic logic [31:0] pattern(input logic [22:0] addr, input logic [3:0] be);
        logic [31:0] word;
        word = {addr[15:0] ^ 16'hA5A5, addr[15:0]};
        for (int i = 0; i < 4; i++) begin
            if (!be[i]) word[i*8 +: 8] = 8'h00;
        end
        return word;
    endfunction

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state                   <= IDLE;
            wait_cnt                <= 4'd0;
            lat_cnt                 <= 4'd0;
            beats_left              <= 4'd0;
            cur_addr                <= 23'd0;
            cur_be                  <= 4'd0;
            flash_mem_waitrequest   <= 1'b1;
            flash_mem_readdata      <= 32'h0;
            flash_mem_readdatavalid <= 1'b0;
        end else begin
            flash_mem_waitrequest   <= 1'b1;
            flash_mem_readdatavalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (flash_mem_read || flash_mem_write) begin
                        state    <= WAIT;
                        wait_cnt <= 4'(WAIT_CYCLES - 1);
                    end
                end
                WAIT: begin
                    if (!flash_mem_read && !flash_mem_write) begin
                        state <= IDLE;
                    end else if (wait_cnt == 4'd0) begin
                        state                 <= ACCEPT;
                        flash_mem_waitrequest <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ACCEPT: begin
                    // Read wins when both strobes are high; a lone write or nothing ends here.
                    if (flash_mem_read) begin
                        state      <= LATENCY;
                        cur_addr   <= flash_mem_address;
                        cur_be     <= flash_mem_byteenable;
                        beats_left <= (flash_mem_burstcount == 4'd0) ? 4'd1 : flash_mem_burstcount;
                        lat_cnt    <= 4'(READ_LATENCY - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
                LATENCY, BURST: begin
                    if (state == BURST || lat_cnt == 4'd0) begin
                        flash_mem_readdatavalid <= 1'b1;
                        flash_mem_readdata      <= pattern(cur_addr, cur_be);
                        cur_addr                <= cur_addr + 23'd1;
                        beats_left              <= beats_left - 4'd1;
                        state                   <= (beats_left == 4'd1) ? IDLE : BURST;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
